// File: rtl/execute_cycle_pkg.sv
// Shared definitions for the EX stage: ALU opcodes and operand-forwarding selects.
package execute_cycle_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_NOR = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the EX stage; all results wrap at DW bits.
module execute_cycle_alu
    import execute_cycle_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic [2:0]    ALUControl,
    output logic [DW-1:0] Result,
    output logic          Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_XOR: Result = A ^ B;
            // Signed compare, flag zero-extended into the full word
            ALU_SLT: Result = {{(DW-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_NOR: Result = ~(A | B);
            ALU_SLL: Result = A << B[4:0];
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// EX pipeline stage: operand forwarding from MEM/WB, ALU, and the EX/MEM register.
module execute_cycle
    import execute_cycle_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RegWriteE,
    input  logic          ALUSrcE,
    input  logic          MemWriteE,
    input  logic          ResultSrcE,
    input  logic [2:0]    ALUControlE,
    input  logic [DW-1:0] RD1_E,
    input  logic [DW-1:0] RD2_E,
    input  logic [DW-1:0] Imm_Ext_E,
    input  logic [AW-1:0] RD_E,
    input  logic [AW-1:0] RS1_E,
    input  logic [AW-1:0] RS2_E,
    input  logic [DW-1:0] PCPlus4E,
    input  logic          RegWriteW,
    input  logic [AW-1:0] RDW,
    input  logic [DW-1:0] ResultW,
    input  logic          FlushE,
    output logic          ZeroE,
    output logic          RegWriteM,
    output logic          MemWriteM,
    output logic          ResultSrcM,
    output logic [AW-1:0] RD_M,
    output logic [DW-1:0] ALUResultM,
    output logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] PCPlus4M
);

    logic [1:0]    fwd_a, fwd_b;
    logic [DW-1:0] src_a, fwd_rd2, src_b, alu_result;

    logic          reg_write_q,   reg_write_d;
    logic          mem_write_q,   mem_write_d;
    logic          result_src_q,  result_src_d;
    logic [AW-1:0] rd_q,          rd_d;
    logic [DW-1:0] alu_result_q,  alu_result_d;
    logic [DW-1:0] write_data_q,  write_data_d;
    logic [DW-1:0] pc_plus4_q,    pc_plus4_d;

    function automatic logic [DW-1:0] fwd_mux(input logic [1:0] sel, input logic [DW-1:0] rf,
                                             input logic [DW-1:0] wb, input logic [DW-1:0] mem);
        case (sel)
            FWD_MEM: return mem;
            FWD_WB:  return wb;
            default: return rf;
        endcase
    endfunction

    // MEM wins over WB because it holds the younger write; r0 is hardwired zero
    always_comb begin
        fwd_a = FWD_REG;
        if (reg_write_q && rd_q != '0 && rd_q == RS1_E)
            fwd_a = FWD_MEM;
        else if (RegWriteW && RDW != '0 && RDW == RS1_E)
            fwd_a = FWD_WB;

        fwd_b = FWD_REG;
        if (reg_write_q && rd_q != '0 && rd_q == RS2_E)
            fwd_b = FWD_MEM;
        else if (RegWriteW && RDW != '0 && RDW == RS2_E)
            fwd_b = FWD_WB;
    end

    assign src_a   = fwd_mux(fwd_a, RD1_E, ResultW, alu_result_q);
    assign fwd_rd2 = fwd_mux(fwd_b, RD2_E, ResultW, alu_result_q);
    assign src_b   = ALUSrcE ? Imm_Ext_E : fwd_rd2;

    execute_cycle_alu #(.DW(DW)) u_alu (
        .A          (src_a),
        .B          (src_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result),
        .Zero       (ZeroE)
    );

    // A flush turns the slot into an all-zero bubble
    always_comb begin
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
        rd_d         = RD_E;
        alu_result_d = alu_result;
        write_data_d = fwd_rd2;
        pc_plus4_d   = PCPlus4E;
        if (FlushE) begin
            reg_write_d  = 1'b0;
            mem_write_d  = 1'b0;
            result_src_d = 1'b0;
            rd_d         = '0;
            alu_result_d = '0;
            write_data_d = '0;
            pc_plus4_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign RD_M       = rd_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: table of ALU/store vectors plus forwarding and reset sequences.
module tb_execute_cycle;

    logic        clk;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCPlus4E, ResultW;
    logic [4:0]  RD_E, RS1_E, RS2_E, RDW;
    logic        RegWriteW, FlushE;
    logic        ZeroE, RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    execute_cycle #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .RD_E(RD_E), .RS1_E(RS1_E), .RS2_E(RS2_E), .PCPlus4E(PCPlus4E),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .ZeroE(ZeroE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] a, b;
        logic        src;
        logic [31:0] imm;
        logic        rw, mw, rs, fl;
        logic [4:0]  rd, rs1, rs2;
        logic        rww;
        logic [4:0]  rdw;
        logic [31:0] resw;
        logic [31:0] e_alu, e_wd;
        logic        e_z;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int pc_n   = 0;
    vec_t tbl[13];

    function automatic vec_t mk(logic [2:0] ctl, logic [31:0] a, logic [31:0] b, logic src,
                                logic [31:0] imm, logic rw, logic mw, logic fl,
                                logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic rww, logic [4:0] rdw, logic [31:0] resw,
                                logic [31:0] e_alu, logic [31:0] e_wd, logic e_z);
        vec_t v;
        v.ctl = ctl; v.a = a; v.b = b; v.src = src; v.imm = imm;
        v.rw = rw; v.mw = mw; v.rs = 1'b0; v.fl = fl;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.rww = rww; v.rdw = rdw; v.resw = resw;
        v.e_alu = e_alu; v.e_wd = e_wd; v.e_z = e_z;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Drive one instruction, check ZeroE before the edge and EX/MEM after it
    task automatic step(input string name, input vec_t v);
        logic [31:0] pc;
        pc = 32'h100 + 32'(pc_n * 4);
        pc_n++;
        ALUControlE = v.ctl; RD1_E = v.a; RD2_E = v.b; ALUSrcE = v.src; Imm_Ext_E = v.imm;
        RegWriteE = v.rw; MemWriteE = v.mw; ResultSrcE = v.rs; FlushE = v.fl;
        RD_E = v.rd; RS1_E = v.rs1; RS2_E = v.rs2;
        RegWriteW = v.rww; RDW = v.rdw; ResultW = v.resw; PCPlus4E = pc;
        #1;
        chk({name, " ZeroE"}, 32'(ZeroE), 32'(v.e_z));
        @(posedge clk);
        #1;
        chk({name, " ALUResultM"}, ALUResultM, v.e_alu);
        chk({name, " WriteDataM"}, WriteDataM, v.e_wd);
        chk({name, " RegWriteM"}, 32'(RegWriteM), v.fl ? 32'd0 : 32'(v.rw));
        chk({name, " MemWriteM"}, 32'(MemWriteM), v.fl ? 32'd0 : 32'(v.mw));
        chk({name, " ResultSrcM"}, 32'(ResultSrcM), v.fl ? 32'd0 : 32'(v.rs));
        chk({name, " RD_M"}, 32'(RD_M), v.fl ? 32'd0 : 32'(v.rd));
        chk({name, " PCPlus4M"}, PCPlus4M, v.fl ? 32'd0 : pc);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " RegWriteM"}, 32'(RegWriteM), 32'd0);
        chk({name, " MemWriteM"}, 32'(MemWriteM), 32'd0);
        chk({name, " ResultSrcM"}, 32'(ResultSrcM), 32'd0);
        chk({name, " RD_M"}, 32'(RD_M), 32'd0);
        chk({name, " ALUResultM"}, ALUResultM, 32'd0);
        chk({name, " WriteDataM"}, WriteDataM, 32'd0);
        chk({name, " PCPlus4M"}, PCPlus4M, 32'd0);
    endtask

    initial begin
        vec_t v;
        // ctl a b src imm rw mw fl rd rs1 rs2 rww rdw resw e_alu e_wd e_z
        tbl[0]  = mk(3'b000, 7, 5, 0, 0, 1, 0, 0, 10, 1, 2, 0, 0, 0, 32'd12, 5, 0);
        tbl[1]  = mk(3'b001, 7, 5, 0, 0, 1, 0, 0, 10, 1, 2, 0, 0, 0, 32'd2, 5, 0);
        tbl[2]  = mk(3'b010, 7, 5, 0, 0, 1, 0, 0, 10, 1, 2, 0, 0, 0, 32'd5, 5, 0);
        tbl[2].rs = 1'b1;
        tbl[3]  = mk(3'b011, 7, 5, 0, 0, 1, 0, 0, 10, 1, 2, 0, 0, 0, 32'd7, 5, 0);
        tbl[4]  = mk(3'b100, 7, 5, 0, 0, 1, 0, 0, 10, 1, 2, 0, 0, 0, 32'd2, 5, 0);
        tbl[5]  = mk(3'b101, 7, 5, 0, 0, 1, 0, 0, 10, 1, 2, 0, 0, 0, 32'd0, 5, 1);
        tbl[6]  = mk(3'b110, 7, 5, 0, 0, 1, 0, 0, 10, 1, 2, 0, 0, 0, 32'hFFFF_FFF8, 5, 0);
        tbl[7]  = mk(3'b111, 7, 5, 0, 0, 1, 0, 0, 10, 1, 2, 0, 0, 0, 32'd224, 5, 0);
        tbl[8]  = mk(3'b001, 9, 9, 0, 0, 1, 0, 0, 10, 1, 2, 0, 0, 0, 32'd0, 9, 1);
        tbl[9]  = mk(3'b101, 32'hFFFF_FFFD, 5, 0, 0, 1, 0, 0, 10, 1, 2, 0, 0, 0, 32'd1, 5, 0);
        tbl[10] = mk(3'b111, 1, 32'h3F, 0, 0, 1, 0, 0, 10, 1, 2, 0, 0, 0, 32'h8000_0000, 32'h3F, 0);
        tbl[11] = mk(3'b000, 4, 32'hDEAD, 1, 16, 0, 1, 0, 11, 1, 2, 0, 0, 0, 32'd20, 32'hDEAD, 0);
        tbl[12] = mk(3'b000, 4, 32'hDEAD, 1, 16, 0, 1, 1, 11, 1, 2, 0, 0, 0, 32'd0, 32'd0, 0);

        rst = 1'b1;
        RegWriteE = 1'b1; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; ALUControlE = 3'b000;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0; RS1_E = 0; RS2_E = 0; PCPlus4E = 0;
        RegWriteW = 0; RDW = 0; ResultW = 0; FlushE = 0;
        #1 rst = 1'b0;
        #1 chk_all_zero("reset_async");
        @(posedge clk);
        #3 rst = 1'b1;

        for (int i = 0; i < 13; i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // MEM forwarding on A, then on B into both ALU and store data
        step("memfwd_p", mk(3'b000, 3, 4, 0, 0, 1, 0, 0, 8, 1, 2, 0, 0, 0, 32'd7, 4, 0));
        step("memfwd_a", mk(3'b000, 0, 1, 0, 0, 1, 0, 0, 9, 8, 2, 0, 0, 0, 32'd8, 1, 0));
        step("memfwd_b", mk(3'b000, 1, 0, 0, 0, 1, 0, 0, 3, 1, 9, 0, 0, 0, 32'd9, 8, 0));

        // MEM beats WB when both match; WB used once MEM is not writing
        step("prio_p",   mk(3'b000, 3, 4, 0, 0, 1, 0, 0, 8, 1, 2, 0, 0, 0, 32'd7, 4, 0));
        step("prio_mem", mk(3'b000, 0, 0, 0, 0, 1, 0, 0, 3, 8, 2, 1, 8, 100, 32'd7, 0, 0));
        step("prio_p2",  mk(3'b000, 3, 4, 0, 0, 0, 0, 0, 8, 1, 2, 0, 0, 0, 32'd7, 4, 0));
        step("prio_wb",  mk(3'b000, 0, 0, 0, 0, 1, 0, 0, 3, 8, 2, 1, 8, 100, 32'd100, 0, 0));

        // r0 is never forwarded from MEM or WB
        step("r0_p",   mk(3'b000, 4, 5, 0, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 32'd9, 5, 0));
        step("r0_use", mk(3'b000, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 1, 0, 55, 32'd0, 0, 1));

        // Reset mid-cycle clears outputs at once and drops the in-flight r8 result
        step("rst_p", mk(3'b000, 3, 4, 0, 0, 1, 0, 0, 8, 1, 2, 0, 0, 0, 32'd7, 4, 0));
        RegWriteE = 1'b1; FlushE = 1'b1;
        #2 rst = 1'b0;
        #1 chk_all_zero("reset_mid");
        #2 rst = 1'b1;
        FlushE = 1'b0;
        step("rst_after", mk(3'b000, 50, 0, 0, 0, 1, 0, 0, 3, 8, 2, 0, 0, 0, 32'd50, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
